// File: rtl/display_scan_hex.sv
// Multiplexed common-anode hex display scanner: per-frame input snapshot, PWM brightness, guard band.
// Optional leading-zero blanking is compiled in with `define DISPLAY_SCAN_LZB_EN.
module display_scan_hex #(
    parameter int N_DIGITS    = 8,
    parameter int DIV_BITS    = 13,
    parameter int GUARD       = 16,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     strobe,
    output logic                    frame_start
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IW-1:0]       IDX_TOP = IW'(N_DIGITS - 1);
    localparam logic [DIV_BITS-1:0] GUARD_C = DIV_BITS'(GUARD);

    logic [DIV_BITS-1:0]    sc_q, sc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*N_DIGITS-1:0]  data_sh_q, data_sh_d;
    logic [N_DIGITS-1:0]    dp_sh_q, dp_sh_d;
    logic [N_DIGITS-1:0]    en_sh_q, en_sh_d;
    logic [BRIGHT_BITS-1:0] bright_sh_q, bright_sh_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [N_DIGITS-1:0]    strobe_q, strobe_d;
    logic                   frame_start_q, frame_start_d;

    logic                   snap;
    logic [N_DIGITS-1:0]    en_eff;
    logic [N_DIGITS-1:0]    sel_onehot;
    logic [3:0]             nib_sel;
    logic                   dp_sel;
    logic                   en_sel;
    logic                   on;
`ifdef DISPLAY_SCAN_LZB_EN
    logic                   zeros_above;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h18;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h27;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        snap = (idx_q == IDX_TOP) && (sc_q == '0);

        sc_d  = sc_q + DIV_BITS'(1);
        idx_d = idx_q;
        if (sc_q == '1) begin
            idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IW'(1);
        end

        // The snapshot cycle already displays the freshly captured values.
        data_sh_d   = snap ? data       : data_sh_q;
        dp_sh_d     = snap ? dp_in      : dp_sh_q;
        en_sh_d     = snap ? digit_en   : en_sh_q;
        bright_sh_d = snap ? brightness : bright_sh_q;

        en_eff = en_sh_d;
`ifdef DISPLAY_SCAN_LZB_EN
        zeros_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (i != 0 && zeros_above && data_sh_d[4*i +: 4] == 4'h0 && !dp_sh_d[i]) begin
                en_eff[i] = 1'b0;
            end
            zeros_above = zeros_above && (data_sh_d[4*i +: 4] == 4'h0);
        end
`endif

        sel_onehot = '0;
        nib_sel    = 4'h0;
        dp_sel     = 1'b0;
        en_sel     = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_onehot[i] = 1'b1;
                nib_sel       = data_sh_d[4*i +: 4];
                dp_sel        = dp_sh_d[i];
                en_sel        = en_eff[i];
            end
        end

        on = (sc_q >= GUARD_C)
             && (sc_q[DIV_BITS-1 -: BRIGHT_BITS] <= bright_sh_d)
             && en_sel;

        strobe_d      = '1;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;
        if (on) begin
            strobe_d = ~sel_onehot;
            seg_d    = hex7(nib_sel);
            dp_d     = ~dp_sel;
        end
        frame_start_d = snap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc_q          <= '0;
            idx_q         <= IDX_TOP;
            data_sh_q     <= '0;
            dp_sh_q       <= '0;
            en_sh_q       <= '0;
            bright_sh_q   <= '0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            strobe_q      <= '1;
            frame_start_q <= 1'b0;
        end else begin
            sc_q          <= sc_d;
            idx_q         <= idx_d;
            data_sh_q     <= data_sh_d;
            dp_sh_q       <= dp_sh_d;
            en_sh_q       <= en_sh_d;
            bright_sh_q   <= bright_sh_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            strobe_q      <= strobe_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign strobe      = strobe_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_hex.sv
// Bench for display_scan_hex: directed scenarios plus random inputs against a frame/slot arithmetic model.
module tb_display_scan_hex;

    localparam int N     = 4;
    localparam int DIVB  = 4;
    localparam int G     = 2;
    localparam int BB    = 2;
    localparam int SLOT  = 1 << DIVB;
    localparam int FRAME = N * SLOT;
    localparam int STEP  = SLOT >> BB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [1:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  strobe;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int t = 0;

    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_en;
    logic [1:0]  m_bright;

    display_scan_hex #(
        .N_DIGITS(N), .DIV_BITS(DIVB), .GUARD(G), .BRIGHT_BITS(BB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data(data), .dp_in(dp_in),
        .digit_en(digit_en), .brightness(brightness), .seg(seg), .dp(dp),
        .strobe(strobe), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0d time=%0t)", tag, obs, exp, t, $time);
        end
    endtask

    function automatic logic [6:0] font(input int v);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
        return tbl[v];
    endfunction

    function automatic bit blanked(input int d);
`ifdef DISPLAY_SCAN_LZB_EN
        return (d != 0) && !m_dp[d] && ((m_data >> (4 * d)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: model the (slot, position) state at this edge, then compare the registered result.
    task automatic step();
        int d, pos;
        bit on;
        logic [3:0] e_strobe;
        logic [6:0] e_seg;
        logic       e_dp;
        if (t % FRAME == 0) begin
            m_data = data; m_dp = dp_in; m_en = digit_en; m_bright = brightness;
        end
        d   = N - 1 - (t / SLOT) % N;
        pos = t % SLOT;
        on  = (pos >= G) && ((pos / STEP) <= int'(m_bright)) && m_en[d] && !blanked(d);
        e_strobe = on ? ~(4'b0001 << d) : 4'hF;
        e_seg    = on ? font(int'(m_data[4*d +: 4])) : 7'h7F;
        e_dp     = on ? ~m_dp[d] : 1'b1;
        @(posedge clk);
        #1;
        chk("strobe", 32'(strobe), 32'(e_strobe));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_start", 32'(frame_start), 32'(t % FRAME == 0));
        chk("onehot", 32'($countones(~strobe) <= 1), 32'd1);
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        data = 16'h1A3F; dp_in = 4'h0; digit_en = 4'hF; brightness = 2'd3;
        #12;
        chk("rst_strobe", 32'(strobe), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        t = 0;

        run(2 * FRAME);
        brightness = 2'd0;
        run(FRAME);
        brightness = 2'd1;
        run(FRAME);
        brightness = 2'd3;
        run(2 * SLOT);
        data = 16'hFFFF;
        run(2 * SLOT + FRAME);
        digit_en = 4'b1010; dp_in = 4'b0010; data = 16'h1A3F;
        run(FRAME);
`ifdef DISPLAY_SCAN_LZB_EN
        digit_en = 4'hF; dp_in = 4'h0; data = 16'h0040;
        run(FRAME);
        data = 16'h0000;
        run(FRAME);
`endif

        // Asynchronous reset while digit 1 is lit.
        digit_en = 4'hF; dp_in = 4'h0; data = 16'h1A3F; brightness = 2'd3;
        run(FRAME + 2 * SLOT + 8);
        chk("pre_rst_strobe", 32'(strobe), 32'hD);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_strobe", 32'(strobe), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_dp", 32'(dp), 32'd1);
        @(posedge clk);
        #1;
        chk("held_strobe", 32'(strobe), 32'hF);
        @(negedge clk);
        reset_n = 1'b1;
        t = 0;
        run(FRAME + SLOT);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) begin
                data       = 16'($urandom) & {{4{$urandom_range(1) == 1'b1}},
                                              {4{$urandom_range(1) == 1'b1}},
                                              {4{$urandom_range(1) == 1'b1}}, 4'hF};
                dp_in      = 4'($urandom);
                digit_en   = 4'($urandom);
                brightness = 2'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_hex.md
Name: display_scan_hex

Overview:
- Parametrised multiplexed hex driver for common-anode 7-segment banks. Supersedes the fixed 8-digit scanner.
- Supports N digits and per-digit decimal points and enable mask. Adds a PWM brightness control and an inter-digit ghosting guard.
- Display data is snapshotted once per frame, so a digit never shows values from two different updates (no tearing).
- Sits between status/debug registers and the board display pins.

Parameters:
- N_DIGITS, 8, number of digits scanned; data width is 4*N_DIGITS.
- DIV_BITS, 13, each digit slot lasts 2^DIV_BITS clocks.
- GUARD, 16, clocks at the start of each slot with all strobes inactive; legal range 0 to 2^(DIV_BITS-1).
- BRIGHT_BITS, 3, width of the brightness input; must be ≤ DIV_BITS.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- data, in, 4*N_DIGITS, hex nibbles, MSB nibble = leftmost digit.
- dp_in, in, N_DIGITS, decimal point per digit (bit i pairs with data[4i+3:4i]); 1 = lit.
- digit_en, in, N_DIGITS, per-digit enable; 0 = digit never strobed.
- brightness, in, BRIGHT_BITS, on-time select.
- seg, out, 7, segments {g,f,e,d,c,b,a}, active-low.
- dp, out, 1, decimal point, active-low.
- strobe, out, N_DIGITS, digit anodes, active-low, at most one bit low.
- frame_start, out, 1, one-clock pulse at the start of each frame.

Behaviour:
- Reset (async, reset_n=0):
  - seg=7'h7F, dp=1, strobe=all ones, frame_start=0.
  - idx=N_DIGITS-1, sc=0, shadow registers cleared to 0.
- Counters:
  - sc (DIV_BITS wide) increments every clock.
  - On sc wrap to 0, idx decrements; at idx=0 it wraps back to N_DIGITS-1.
  - Scan order: digit N-1 first, down to digit 0. Frame length = N_DIGITS * 2^DIV_BITS clocks.
- Snapshot:
  - In the cycle where idx=N_DIGITS-1 and sc=0, shadow registers capture data, dp_in, digit_en and brightness.
  - Inputs are ignored at all other times.
  - The first frame after reset therefore displays the inputs sampled on the first clock after release.
- Digit on-condition: on = (sc ≥ GUARD) and (sc[DIV_BITS-1 -: BRIGHT_BITS] ≤ bright_sh) and en_sh[idx].
  - brightness = all ones gives the full slot minus the guard.
  - brightness = 0 gives the first 1/2^BRIGHT_BITS of the slot minus the guard; if GUARD ≥ that length, the digit is dark.
- Outputs (all registered, one clock after the (idx, sc) state they represent):
  - strobe[idx]=0 when on, else all ones.
  - seg = hex font of nibble_sh[idx] when on, else 7'h7F.
  - dp = ~dp_sh[idx] when on, else 1.
- Hex font, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, b=03, C=27, d=21, E=06, F=0E.
- frame_start: registered; high for exactly one clock, one clock after the snapshot cycle.
- N_DIGITS=1: idx is constant 0; a frame is one slot.
- Input changes mid-frame have no visible effect until the next frame.
- Reset mid-frame: all outputs go inactive immediately (asynchronously); the scan restarts at digit N-1.

Optional Feature:
- Macro: DISPLAY_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digit i is blanked (treated as en=0) if nibble_sh[i]=0 and every nibble_sh[j] for j>i is 0.
  - Exceptions: i=0 is never blanked, and a digit with dp_sh[i]=1 is never blanked.
  - Computed from shadow values only.
- Undefined: zeros display normally; no blanking logic is synthesised.

Test Plan (N_DIGITS=4, DIV_BITS=4, GUARD=2, BRIGHT_BITS=2 unless noted):
- Reset hold, then release with data=16'h1A3F, brightness=3, digit_en=4'hF, dp_in=0 → output sequence:
  - strobe 1111 for 2 clocks, then 0111 with seg=7'h79 for 14 clocks;
  - then per slot: 1011/7'h08, 1101/7'h30, 1110/7'h0E;
  - period 64 clocks; frame_start pulses every 64 clocks.
- brightness=0 → each strobe low for exactly 2 clocks per 16-clock slot. brightness=1 → low for 6 clocks (sc 2..7).
- Change data to 16'hFFFF at slot 2 of a frame → remaining slots of that frame still show 1A3F; the next frame shows F everywhere.
- digit_en=4'b1010, dp_in=4'b0010 → strobe never 1011 or 1110; dp=0 only while strobe=1101.
- Assert reset_n=0 mid-slot while strobe=1101 → strobe=1111 and seg=7'h7F in the same cycle; after release the scan resumes at strobe 0111.
- With DISPLAY_SCAN_LZB_EN, data=16'h0040 → digits 3 and 2 never strobed; digit 1 shows 4, digit 0 shows 0. With data=0, only digit 0 lit.
